enc4x2_drain: RTL and testbench
===============================

Name: enc4x2_drain

Overview:
- Inverse partner of the 2x4 positive-output, negative-enable decoder.
- Accepts a 4-bit multi-hot request mask and emits, one beat per set bit, the 2-bit code the decoder maps back to that bit. Order is highest bit first.
- Sits upstream of dec2x4, so decoding each emitted beat reproduces the set bits of the original mask one at a time.
- Valid/ready handshake on both sides; negative enable gates all activity.

Parameters:
- N, 4, mask width; fixed at 4 for this block, declared for package consistency.
- W, 2, code width; equals log2(N).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en_n  input  1  active-low enable.
- in_vld  input  1  mask valid.
- in_rdy  output  1  block can accept a mask.
- in  input  4  request mask.
- out_vld  output  1  code valid.
- out_rdy  input  1  downstream accepts code.
- out  output  2  encoded index.
- out_last  output  1  current beat is the final set bit of the mask.

Behaviour:
- One clock (clk); reset (rst) is asynchronous and active-high.
- Reset state: state=IDLE, mask register=0, in_rdy=0 while rst is high, out_vld=0, out=2'b00, out_last=0.
- Code map (exact inverse of dec2x4):
  - bit3 -> 2'b00
  - bit2 -> 2'b01
  - bit1 -> 2'b10
  - bit0 -> 2'b11
- Priority: bit3 highest, bit0 lowest.
- States:
  - IDLE: in_rdy = ~en_n. out_vld=0.
  - DRAIN: in_rdy=0. out_vld = ~en_n. out = code of the highest set bit of the mask register. out_last=1 when exactly one bit remains set.
- Transitions:
  - IDLE, in_vld & in_rdy, in!=0: capture in into the mask register -> DRAIN.
  - IDLE, in_vld & in_rdy, in==0: mask consumed and dropped, stay IDLE (see optional feature).
  - DRAIN, out_vld & out_rdy: clear the served bit. If the remaining mask is 0 -> IDLE, else stay in DRAIN.
  - DRAIN, out_rdy=0: out, out_last and the mask register are held stable. out_vld stays high.
- Latency:
  - Mask accepted at edge k -> first code valid after edge k (cycle k+1).
  - Each subsequent beat follows one cycle after the previous handshake.
  - One bubble cycle in IDLE between masks: no accept in the same cycle as the last beat.
- en_n=1 mid-operation:
  - Pause: in_rdy=0, out_vld=0, all state frozen.
  - Resume on en_n=0 with the identical pending beat.
- rst mid-DRAIN: pending mask discarded immediately, outputs return to reset values.
- out is don't-care while out_vld=0 but must be driven; it holds its last value.

Optional Feature:
- Macro ENC_ZERO_FLAG_EN.
- Defined:
  - Extra output port out_zero (1 bit, resets to 0).
  - An accepted in==0 produces a single beat: out_vld=1, out=2'b00, out_zero=1, out_last=1.
  - The beat is held until out_rdy, then the block returns to IDLE. out_zero=0 on all normal beats.
- Undefined: no out_zero port; zero masks are silently dropped as above.

Decomposition:
- Package enc_pkg contains:
  - state typedef {IDLE, DRAIN}.
  - Constants N=4 and W=2.
  - Code constants CODE_B3..CODE_B0 (00, 01, 10, 11), shared with the decoder bench.
- Natural sub-module prio_enc4x2: combinational.
  - Inputs: 4-bit mask.
  - Outputs: 2-bit code, one-hot clear vector, single-bit-remaining flag.
- Top module: FSM, mask register, handshake.

Test Plan:
- Reset/idle: rst high with in_vld=1 -> in_rdy=0, out_vld=0, out=00, out_last=0. Release rst with en_n=0 -> in_rdy=1.
- Full drain: in=4'b1111, out_rdy=1 -> codes 00, 01, 10, 11 on four consecutive cycles. out_last only on code 11. in_rdy=1 the cycle after.
- Sparse mask with backpressure:
  - in=4'b0101, out_rdy=0 for 3 cycles -> out=01 held stable with out_vld=1.
  - out_rdy=1 -> then out=11 with out_last=1.
- Enable pause: in=4'b1010, assert en_n after the first beat (00 accepted) -> out_vld=0 for the pause. Deassert en_n -> out=10, out_last=1.
- Zero mask:
  - in=4'b0000 accepted, macro undefined -> no out_vld, in_rdy stays 1.
  - Macro defined -> one beat out=00, out_zero=1, out_last=1.
- Round trip and async reset:
  - Feed each emitted out into dec2x4 with EN=0 and OR the decoded results -> equals the original mask for all 15 nonzero masks.
  - Assert rst mid-DRAIN (asynchronously, between clock edges) -> out_vld drops without waiting for a clock edge.

Source files
------------

// File: rtl/enc4x2_drain_pkg.sv
// Shared types and constants for the 4:2 draining encoder and its dec2x4 partner.
// Optional zero-mask beat is enabled by defining ENC_ZERO_FLAG_EN.
package enc_pkg;

  localparam int unsigned N = 4;
  localparam int unsigned W = 2;

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  // Code emitted for each mask bit; dec2x4 maps these back to the same bit
  localparam logic [W-1:0] CODE_B3 = 2'b00;
  localparam logic [W-1:0] CODE_B2 = 2'b01;
  localparam logic [W-1:0] CODE_B1 = 2'b10;
  localparam logic [W-1:0] CODE_B0 = 2'b11;

endpackage

// File: rtl/prio_enc4x2.sv
// Combinational priority encoder: highest set bit wins (bit3 first).
// Also reports the one-hot bit being served and whether it is the only one set.
module prio_enc4x2
  import enc_pkg::*;
(
  input  logic [N-1:0] mask,
  output logic [W-1:0] code,
  output logic [N-1:0] clr,
  output logic         single
);

  // Select the highest set bit and its code
  always_comb begin
    code = CODE_B3;
    clr  = '0;
    if (mask[3]) begin
      code = CODE_B3;
      clr  = 4'b1000;
    end else if (mask[2]) begin
      code = CODE_B2;
      clr  = 4'b0100;
    end else if (mask[1]) begin
      code = CODE_B1;
      clr  = 4'b0010;
    end else if (mask[0]) begin
      code = CODE_B0;
      clr  = 4'b0001;
    end
  end

  // Exactly one bit set: nonzero with no second bit left after clearing the lowest
  assign single = (mask != '0) && ((mask & (mask - N'(1))) == '0);

endmodule

// File: rtl/enc4x2_drain.sv
// Drains a multi-hot request mask as one 2-bit code beat per set bit, highest first.
// Optional ENC_ZERO_FLAG_EN adds out_zero and turns an accepted zero mask into one flagged beat.
module enc4x2_drain
  import enc_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         en_n,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [N-1:0] in,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out,
  output logic         out_last
`ifdef ENC_ZERO_FLAG_EN
  ,
  output logic         out_zero
`endif
);

  state_t       state;
  logic [N-1:0] mask_q;
  logic [N-1:0] clr_q;
  logic [N-1:0] rem;
  logic [N-1:0] enc_in;
  logic [W-1:0] code_n;
  logic [N-1:0] clr_n;
  logic         single_n;
  logic         acc;
  logic         beat;

  // Handshake qualifiers; enable and reset gate both sides immediately
  assign in_rdy  = (state == IDLE) && !en_n && !rst;
  assign out_vld = (state == DRAIN) && !en_n;
  assign acc     = in_vld && in_rdy;
  assign beat    = out_vld && out_rdy;

  // Mask left after the current beat is served
  assign rem    = mask_q & ~clr_q;
  assign enc_in = (state == IDLE) ? in : rem;

  // Encode whatever mask will be presented next cycle
  prio_enc4x2 u_prio (
    .mask   (enc_in),
    .code   (code_n),
    .clr    (clr_n),
    .single (single_n)
  );

  // FSM, mask register and registered beat outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mask_q   <= '0;
      clr_q    <= '0;
      out      <= CODE_B3;
      out_last <= 1'b0;
`ifdef ENC_ZERO_FLAG_EN
      out_zero <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (acc) begin
            if (in != '0) begin
              mask_q   <= in;
              clr_q    <= clr_n;
              out      <= code_n;
              out_last <= single_n;
              state    <= DRAIN;
            end else begin
`ifdef ENC_ZERO_FLAG_EN
              mask_q   <= '0;
              clr_q    <= '0;
              out      <= CODE_B3;
              out_last <= 1'b1;
              out_zero <= 1'b1;
              state    <= DRAIN;
`endif
            end
          end
        end
        DRAIN: begin
          if (beat) begin
            mask_q <= rem;
            if (rem == '0) begin
              out_last <= 1'b0;
`ifdef ENC_ZERO_FLAG_EN
              out_zero <= 1'b0;
`endif
              state    <= IDLE;
            end else begin
              clr_q    <= clr_n;
              out      <= code_n;
              out_last <= single_n;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enc4x2_drain.sv
// Scoreboard bench for enc4x2_drain: directed scenarios plus randomized masks,
// backpressure and enable pauses, with a dec2x4 round-trip check per mask.
module tb_enc4x2_drain;
  import enc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_n;
  logic       in_vld;
  logic       in_rdy;
  logic [3:0] in;
  logic       out_vld;
  logic       out_rdy;
  logic [1:0] out;
  logic       out_last;
`ifdef ENC_ZERO_FLAG_EN
  logic       out_zero;
`endif

  enc4x2_drain dut (
    .clk      (clk),
    .rst      (rst),
    .en_n     (en_n),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in       (in),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out      (out),
    .out_last (out_last)
`ifdef ENC_ZERO_FLAG_EN
    ,
    .out_zero (out_zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] code;
    logic       last;
    logic       zero;
  } beat_t;

  beat_t      exp_q[$];
  logic [3:0] mask_q[$];
  logic [3:0] rt_acc = 4'b0000;
  int         checks = 0;
  int         failures = 0;
  bit         rnd = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: one beat per set bit, highest first, code = 3 - bit index
  task automatic model_push(input logic [3:0] m);
    int    left;
    beat_t b;
    left = 0;
    for (int i = 0; i < 4; i++) if (m[i]) left++;
    if (m == 4'b0000) begin
`ifdef ENC_ZERO_FLAG_EN
      b.code = 2'b00; b.last = 1'b1; b.zero = 1'b1;
      exp_q.push_back(b);
`endif
      return;
    end
    mask_q.push_back(m);
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) begin
        left--;
        b.code = 2'(3 - i);
        b.last = (left == 0);
        b.zero = 1'b0;
        exp_q.push_back(b);
      end
    end
  endtask

  // dec2x4 with EN=0: code c lights bit 3-c
  function automatic logic [3:0] dec2x4(input logic [1:0] c);
    logic [3:0] one;
    one = 4'b0001;
    return one << (3 - int'(c));
  endfunction

  // Monitor: every handshake pops one expected beat
  always @(negedge clk) begin
    beat_t e;
    if (!rst && out_vld && out_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat actual=%0h required=none", out);
      end else begin
        e = exp_q.pop_front();
        check("beat_code", 32'(out), 32'(e.code));
        check("beat_last", 32'(out_last), 32'(e.last));
`ifdef ENC_ZERO_FLAG_EN
        check("beat_zero", 32'(out_zero), 32'(e.zero));
`endif
        if (!e.zero) begin
          rt_acc = rt_acc | dec2x4(out);
          if (e.last) begin
            if (mask_q.size() > 0) check("round_trip", 32'(rt_acc), 32'(mask_q.pop_front()));
            rt_acc = 4'b0000;
          end
        end
      end
    end
  end

  // Random backpressure and enable pauses
  always @(posedge clk) begin
    if (rnd) begin
      #1;
      out_rdy = ($urandom_range(0, 3) != 0);
      en_n    = ($urandom_range(0, 7) == 0);
    end
  end

  // Called and returns at posedge+1
  task automatic send(input logic [3:0] m);
    bit ok;
    ok     = 1'b0;
    in     = m;
    in_vld = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) model_push(m);
    else check("send_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
    in_vld = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && in_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; en_n = 1'b0; in_vld = 1'b1; in = 4'hf; out_rdy = 1'b0;

    // Reset state with a pending request
    #12;
    check("rst_in_rdy", 32'(in_rdy), 32'(0));
    check("rst_out_vld", 32'(out_vld), 32'(0));
    check("rst_out", 32'(out), 32'(0));
    check("rst_out_last", 32'(out_last), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0; in_vld = 1'b0;
    @(negedge clk);
    check("idle_in_rdy", 32'(in_rdy), 32'(1));
    @(posedge clk); #1;

    // Full drain on consecutive cycles, then one idle bubble
    out_rdy = 1'b1;
    send(4'b1111);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("full_vld", 32'(out_vld), 32'(1));
      check("full_busy", 32'(in_rdy), 32'(0));
    end
    @(negedge clk);
    check("full_done_vld", 32'(out_vld), 32'(0));
    check("full_done_rdy", 32'(in_rdy), 32'(1));
    @(posedge clk); #1;

    // Sparse mask under backpressure
    out_rdy = 1'b0;
    send(4'b0101);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_vld", 32'(out_vld), 32'(1));
      check("bp_out", 32'(out), 32'(1));
      check("bp_last", 32'(out_last), 32'(0));
    end
    @(posedge clk); #1;
    out_rdy = 1'b1;
    wait_idle();

    // Enable pause after the first beat
    send(4'b1010);
    @(posedge clk); #1;
    en_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("pause_vld", 32'(out_vld), 32'(0));
      check("pause_rdy", 32'(in_rdy), 32'(0));
    end
    @(posedge clk); #1;
    en_n = 1'b0;
    @(negedge clk);
    check("resume_vld", 32'(out_vld), 32'(1));
    check("resume_out", 32'(out), 32'(2));
    check("resume_last", 32'(out_last), 32'(1));
    wait_idle();

    // Zero mask
    send(4'b0000);
`ifdef ENC_ZERO_FLAG_EN
    @(negedge clk);
    check("zero_vld", 32'(out_vld), 32'(1));
    check("zero_out", 32'(out), 32'(0));
    check("zero_flag", 32'(out_zero), 32'(1));
    check("zero_last", 32'(out_last), 32'(1));
`else
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("zero_no_vld", 32'(out_vld), 32'(0));
      check("zero_rdy", 32'(in_rdy), 32'(1));
    end
`endif
    wait_idle();

    // Round trip over every nonzero mask
    for (int m = 1; m < 16; m++) begin
      send(4'(m));
      wait_idle();
    end

    // Randomized masks, backpressure and pauses
    rnd = 1'b1;
    for (int i = 0; i < 60; i++) send(4'($urandom_range(0, 15)));
    rnd = 1'b0;
    @(posedge clk); #1;
    out_rdy = 1'b1; en_n = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of a drain
    out_rdy = 1'b0;
    send(4'b1100);
    @(negedge clk);
    check("pre_rst_vld", 32'(out_vld), 32'(1));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_vld", 32'(out_vld), 32'(0));
    check("async_rst_rdy", 32'(in_rdy), 32'(0));
    check("async_rst_out", 32'(out), 32'(0));
    check("async_rst_last", 32'(out_last), 32'(0));
    exp_q.delete();
    mask_q.delete();
    rt_acc = 4'b0000;
    @(posedge clk); #1;
    rst = 1'b0; out_rdy = 1'b1;
    @(negedge clk);
    check("post_rst_rdy", 32'(in_rdy), 32'(1));
    check("post_rst_vld", 32'(out_vld), 32'(0));
    @(posedge clk); #1;
    send(4'b0011);
    wait_idle();

    check("pending_beats", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
